// File: rtl/sc_speedtick_generator.sv
// Speed level to periodic active-low move tick; reload only at period boundary.
// Optional macro SC_SPEEDTICK_TICKCOUNT_EN adds an 8-bit emitted-tick counter port.
module sc_speedtick_generator #(
    parameter int SPEEDTICK_LEVELWIDTH  = 8,
    parameter int SPEEDTICK_PERIODWIDTH = 26,
    parameter int SPEEDTICK_BASE_PERIOD = 25_000_000,
    parameter int SPEEDTICK_PERIOD_STEP = 1_000_000,
    parameter int SPEEDTICK_MIN_PERIOD  = 2_500_000
) (
    input  logic                             SC_SPEEDTICK_CLOCK_50,
    input  logic                             SC_SPEEDTICK_RESET_InHigh,
    input  logic [SPEEDTICK_LEVELWIDTH-1:0]  SC_SPEEDTICK_level_InBUS,
    input  logic                             SC_SPEEDTICK_run_InLow,
    output logic                             SC_SPEEDTICK_tick_OutLow,
    output logic [SPEEDTICK_PERIODWIDTH-1:0] SC_SPEEDTICK_period_OutBUS,
    output logic [1:0]                       SC_SPEEDTICK_state_OutBUS
`ifdef SC_SPEEDTICK_TICKCOUNT_EN
    ,
    output logic [7:0]                       SC_SPEEDTICK_tickCount_OutBUS
`endif
);

    localparam int LW = SPEEDTICK_LEVELWIDTH;
    localparam int PW = SPEEDTICK_PERIODWIDTH;
    localparam int CW = PW + LW;

    localparam logic [CW-1:0] BASE_C = CW'(SPEEDTICK_BASE_PERIOD);
    localparam logic [CW-1:0] STEP_C = CW'(SPEEDTICK_PERIOD_STEP);
    localparam logic [CW-1:0] SPAN_C =
        CW'(SPEEDTICK_BASE_PERIOD - SPEEDTICK_MIN_PERIOD);
    localparam logic [PW-1:0] BASE_P = PW'(SPEEDTICK_BASE_PERIOD);
    localparam logic [PW-1:0] MIN_P  = PW'(SPEEDTICK_MIN_PERIOD);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t          state;
    logic [PW-1:0]   counter;
    logic [PW-1:0]   period;
    logic            tick;
    logic [CW-1:0]   prod;
    logic [PW-1:0]   calcPeriod;
`ifdef SC_SPEEDTICK_TICKCOUNT_EN
    logic [7:0]      tickCount;
`endif

    // Wide product so large levels clamp instead of wrapping below MIN.
    always_comb begin
        prod       = CW'(SC_SPEEDTICK_level_InBUS) * STEP_C;
        calcPeriod = MIN_P;
        if (prod < SPAN_C) begin
            calcPeriod = PW'(BASE_C - prod);
        end
    end

    always_ff @(posedge SC_SPEEDTICK_CLOCK_50) begin
        if (SC_SPEEDTICK_RESET_InHigh) begin
            state   <= IDLE;
            counter <= '0;
            period  <= BASE_P;
            tick    <= 1'b1;
`ifdef SC_SPEEDTICK_TICKCOUNT_EN
            tickCount <= '0;
`endif
        end else begin
            tick <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (!SC_SPEEDTICK_run_InLow) begin
                        period  <= calcPeriod;
                        counter <= calcPeriod - PW'(1);
                        state   <= COUNT;
                    end
                end
                // Leaving PAUSE counts on the same edge so a pause costs
                // exactly its own length.
                COUNT, PAUSE: begin
                    if (SC_SPEEDTICK_run_InLow) begin
                        state <= PAUSE;
                    end else begin
                        state <= COUNT;
                        if (counter == '0) begin
                            tick    <= 1'b0;
                            period  <= calcPeriod;
                            counter <= calcPeriod - PW'(1);
`ifdef SC_SPEEDTICK_TICKCOUNT_EN
                            tickCount <= tickCount + 8'd1;
`endif
                        end else begin
                            counter <= counter - PW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign SC_SPEEDTICK_tick_OutLow   = tick;
    assign SC_SPEEDTICK_period_OutBUS = period;
    assign SC_SPEEDTICK_state_OutBUS  = state;
`ifdef SC_SPEEDTICK_TICKCOUNT_EN
    assign SC_SPEEDTICK_tickCount_OutBUS = tickCount;
`endif

endmodule

// File: tb/tb_sc_speedtick_generator.sv
// Directed vector bench for sc_speedtick_generator (BASE=20, STEP=3, MIN=5).
// Define SC_SPEEDTICK_TICKCOUNT_EN to also exercise the tick counter wrap.
module tb_sc_speedtick_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] level = 8'd0;
    logic       run = 1'b1;
    logic       tick;
    logic [7:0] period;
    logic [1:0] state;
`ifdef SC_SPEEDTICK_TICKCOUNT_EN
    logic [7:0] tickCount;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sc_speedtick_generator #(
        .SPEEDTICK_LEVELWIDTH (8),
        .SPEEDTICK_PERIODWIDTH(8),
        .SPEEDTICK_BASE_PERIOD(20),
        .SPEEDTICK_PERIOD_STEP(3),
        .SPEEDTICK_MIN_PERIOD (5)
    ) dut (
        .SC_SPEEDTICK_CLOCK_50     (clk),
        .SC_SPEEDTICK_RESET_InHigh (rst),
        .SC_SPEEDTICK_level_InBUS  (level),
        .SC_SPEEDTICK_run_InLow    (run),
        .SC_SPEEDTICK_tick_OutLow  (tick),
        .SC_SPEEDTICK_period_OutBUS(period),
        .SC_SPEEDTICK_state_OutBUS (state)
`ifdef SC_SPEEDTICK_TICKCOUNT_EN
        ,
        .SC_SPEEDTICK_tickCount_OutBUS(tickCount)
`endif
    );

    typedef struct {
        logic [7:0] lvl;
        int         expPeriod;
        int         expFirst;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clocks until tick goes low (1 = the very next edge); -1 on timeout.
    task automatic wait_tick(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (tick == 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic [7:0] lvl);
        rst   = 1'b1;
        run   = 1'b1;
        level = lvl;
        step();
        check("rst_state", int'(state), 0);
        check("rst_tick", int'(tick), 1);
        check("rst_period", int'(period), 20);
        rst = 1'b0;
        run = 1'b0;
    endtask

    initial begin
        int n;
        int bad;

        vecs[0] = '{8'd0,   20, 21};
        vecs[1] = '{8'd4,    8,  9};
        vecs[2] = '{8'd5,    5,  6};
        vecs[3] = '{8'd6,    5,  6};
        vecs[4] = '{8'd255,  5,  6};
        vecs[5] = '{8'd1,   17, 18};
        vecs[6] = '{8'd2,   14, 15};
        vecs[7] = '{8'd3,   11, 12};

        step();
        foreach (vecs[v]) begin
            do_reset(vecs[v].lvl);
            wait_tick(n);
            check($sformatf("first_l%0d", vecs[v].lvl), n, vecs[v].expFirst);
            check($sformatf("period_l%0d", vecs[v].lvl), int'(period),
                  vecs[v].expPeriod);
            for (int k = 0; k < 3; k++) begin
                wait_tick(n);
                check($sformatf("gap_l%0d", vecs[v].lvl), n,
                      vecs[v].expPeriod);
            end
        end

        // Level change mid-period waits for the current period to finish.
        do_reset(8'd0);
        wait_tick(n);
        check("chg_first", n, 21);
        repeat (5) step();
        level = 8'd4;
        wait_tick(n);
        check("chg_finish", n, 15);
        wait_tick(n);
        check("chg_gap1", n, 8);
        check("chg_period", int'(period), 8);
        wait_tick(n);
        check("chg_gap2", n, 8);

        // Seven-clock pause mid-count delays the tick by exactly seven.
        level = 8'd0;
        do_reset(8'd0);
        wait_tick(n);
        check("pause_first", n, 21);
        repeat (5) step();
        run = 1'b1;
        bad = 0;
        repeat (7) begin
            step();
            if (tick == 1'b0) bad++;
        end
        check("pause_state", int'(state), 2);
        check("pause_notick", bad, 0);
        run = 1'b0;
        wait_tick(n);
        check("pause_resume", n, 15);

        // Pause landing on the counter==0 cycle fires right after resume.
        repeat (19) step();
        run = 1'b1;
        bad = 0;
        repeat (3) begin
            step();
            if (tick == 1'b0) bad++;
        end
        check("pz_notick", bad, 0);
        check("pz_state", int'(state), 2);
        run = 1'b0;
        wait_tick(n);
        check("pz_fire", n, 1);
        wait_tick(n);
        check("pz_gap", n, 20);

        // Reset at counter=3 abandons the period.
        do_reset(8'd4);
        wait_tick(n);
        check("mr_first", n, 9);
        repeat (4) step();
        rst = 1'b1;
        step();
        check("mr_state", int'(state), 0);
        check("mr_tick", int'(tick), 1);
        check("mr_period", int'(period), 20);
        rst = 1'b0;
        run = 1'b1;
        bad = 0;
        repeat (30) begin
            step();
            if (tick == 1'b0 || state != 2'b00) bad++;
        end
        check("mr_idle", bad, 0);
        run = 1'b0;
        wait_tick(n);
        check("mr_restart", n, 9);

`ifdef SC_SPEEDTICK_TICKCOUNT_EN
        do_reset(8'd5);
        check("tc_reset", int'(tickCount), 0);
        wait_tick(n);
        check("tc_one", int'(tickCount), 1);
        bad = 0;
        repeat (254) begin
            wait_tick(n);
            if (n != 5) bad++;
        end
        check("tc_gaps", bad, 0);
        check("tc_255", int'(tickCount), 255);
        wait_tick(n);
        check("tc_wrap", int'(tickCount), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
